// File: rtl/fifo_read_packer.sv
// fifo_read_packer: read-side consumer of the async FIFO (r_clk domain).
// Drains size-bit entries, absorbs the FIFO's one-cycle read latency, and
// packs RATIO consecutive entries (first entry in the LSB slot) into one wide
// word that is offered on a valid/ready handshake. flush emits a zero-padded
// partial word once per episode.
module fifo_read_packer #(
    parameter int size  = 8,
    parameter int RATIO = 4
) (
    input  logic                       r_clk,
    input  logic                       clrN,
    input  logic                       emptyN,
    output logic                       r_en,
    input  logic [size-1:0]            dataout,
    input  logic                       flush,
    output logic [size*RATIO-1:0]      word_out,
    output logic [$clog2(RATIO+1)-1:0] word_cnt,
    output logic                       word_valid,
    input  logic                       word_ready
);
    localparam int CW = $clog2(RATIO + 1);
    localparam int W  = size * RATIO;
    localparam logic [CW-1:0] FULL    = CW'(RATIO);
    localparam logic [CW:0]   FULL_EXT = (CW + 1)'(RATIO);

    logic [W-1:0]  asm_q, asm_d;
    logic [CW-1:0] fill_q, fill_d;
    logic          pend_q;
    logic [W-1:0]  word_q;
    logic [CW-1:0] cnt_q;
    logic          valid_q;

    logic          slot_free, full_xfer, flush_xfer, xfer;
    logic [CW-1:0] base;
    logic [CW:0]   inflight;

    assign slot_free  = !valid_q || word_ready;
    assign full_xfer  = (fill_q == FULL) && slot_free;
    assign flush_xfer = flush && !pend_q && (fill_q != '0) && (fill_q < FULL) && slot_free;
    assign xfer       = full_xfer || flush_xfer;
    assign inflight   = {1'b0, fill_q} + {{CW{1'b0}}, pend_q};

    // Read when the landing slot is guaranteed. Besides the plain room check,
    // a read may be issued while the pending entry is the one completing the
    // word, provided the output slot is free now: no transfer can happen this
    // cycle, so the slot is still free next cycle and the full transfer there
    // moves the new entry to slot 0. This keeps streaming bubble-free.
    assign r_en = clrN && emptyN && !flush &&
                  ((inflight < FULL_EXT) || full_xfer ||
                   (pend_q && (inflight == FULL_EXT) && slot_free));

    // Start from an empty assembler on transfer, then land the pending entry.
    assign base = xfer ? '0 : fill_q;

    // Next assembler contents: cleared on transfer, pending read lands at base.
    always_comb begin
        asm_d  = xfer ? '0 : asm_q;
        fill_d = base + CW'(pend_q);
        if (pend_q) begin
            for (int k = 0; k < RATIO; k++) begin
                if (base == CW'(k)) asm_d[k*size +: size] = dataout;
            end
        end
    end

    // Assembler, fill count and read-latency tracker.
    always_ff @(posedge r_clk or negedge clrN) begin
        if (!clrN) begin
            asm_q  <= '0;
            fill_q <= '0;
            pend_q <= 1'b0;
        end else begin
            asm_q  <= asm_d;
            fill_q <= fill_d;
            pend_q <= r_en;
        end
    end

    // Output register: loads on transfer, valid drops after an unreplaced handshake.
    always_ff @(posedge r_clk or negedge clrN) begin
        if (!clrN) begin
            word_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else if (xfer) begin
            word_q  <= asm_q;
            cnt_q   <= full_xfer ? FULL : fill_q;
            valid_q <= 1'b1;
        end else if (word_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign word_out   = word_q;
    assign word_cnt   = cnt_q;
    assign word_valid = valid_q;

endmodule

// File: tb/tb_fifo_read_packer.sv
// Bench for fifo_read_packer: a queue-based FIFO model feeds the DUT, a
// consumed-entry queue predicts every accepted word, and directed phases pin
// reset, streaming, backpressure, empty gaps and flush behaviour.
module tb_fifo_read_packer;
    localparam int SZ = 8;
    localparam int R  = 4;
    localparam int W  = SZ * R;

    logic          r_clk, clrN, emptyN, r_en, flush, word_valid, word_ready;
    logic [SZ-1:0] dataout;
    logic [W-1:0]  word_out;
    logic [2:0]    word_cnt;

    fifo_read_packer #(.size(SZ), .RATIO(R)) dut (
        .r_clk(r_clk), .clrN(clrN), .emptyN(emptyN), .r_en(r_en),
        .dataout(dataout), .flush(flush), .word_out(word_out),
        .word_cnt(word_cnt), .word_valid(word_valid), .word_ready(word_ready)
    );

    initial begin
        r_clk = 1'b0;
        forever #5 r_clk = ~r_clk;
    end

    int checks = 0;
    int errors = 0;
    logic [SZ-1:0] fq[$];   // FIFO contents not yet read
    logic [SZ-1:0] cq[$];   // entries read but not yet delivered downstream
    logic [W-1:0]  wlog[$];
    int            cntlog[$];
    int            cyclog[$];
    int            n_words = 0, n_reads = 0, ren_run = 0, ren_max = 0, cycle = 0;
    logic          gate = 1'b1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge r_clk);
            #1;
        end
    endtask

    task automatic wait_words(input int target, input int budget, input string nm);
        int i;
        i = 0;
        while (n_words < target && i < budget) begin
            cyc(1);
            i++;
        end
        checks++;
        if (n_words < target) begin
            errors++;
            $display("FAIL %s: got %0d words expected %0d within %0d cycles", nm, n_words, target, budget);
        end
    endtask

    // Monitor: protocol checks and word prediction at negedge, FIFO model at posedge.
    initial begin : mon
        logic          s_ren, held, flush_seen, ok;
        logic [W-1:0]  hold_w, exp_w;
        logic [2:0]    hold_c;
        int            c;
        s_ren = 0; held = 0; flush_seen = 0;
        hold_w = '0; hold_c = '0;
        emptyN = 1'b0;
        dataout = '0;
        forever begin
            @(negedge r_clk);
            cycle++;
            if (!clrN) begin
                cq.delete();
                s_ren = 0; held = 0; flush_seen = 0; ren_run = 0;
            end else begin
                checks++;
                if (r_en && (!emptyN || flush)) begin
                    errors++;
                    $display("FAIL rd_protocol: r_en=%0b with emptyN=%0b flush=%0b", r_en, emptyN, flush);
                end
                if (held) begin
                    checks++;
                    if (!word_valid || word_out !== hold_w || word_cnt !== hold_c) begin
                        errors++;
                        $display("FAIL hold_stable: got v=%0b %0h/%0d expected v=1 %0h/%0d",
                                 word_valid, word_out, word_cnt, hold_w, hold_c);
                    end
                end
                held = word_valid && !word_ready;
                hold_w = word_out;
                hold_c = word_cnt;
                if (flush) flush_seen = 1;
                if (word_valid && word_ready) begin
                    c = int'(word_cnt);
                    ok = (c >= 1) && (c <= R) && (c == R || flush_seen) && (cq.size() >= c);
                    exp_w = '0;
                    if (ok) for (int k = 0; k < c; k++) exp_w[k*SZ +: SZ] = cq[k];
                    checks++;
                    if (!ok || word_out !== exp_w) begin
                        errors++;
                        $display("FAIL word_model: got %0h cnt %0d expected %0h (pending %0d, flush_seen %0b)",
                                 word_out, c, exp_w, cq.size(), flush_seen);
                    end
                    for (int k = 0; k < c && cq.size() > 0; k++) void'(cq.pop_front());
                    if (c < R) flush_seen = 0;
                    wlog.push_back(word_out);
                    cntlog.push_back(c);
                    cyclog.push_back(cycle);
                    n_words++;
                end
                s_ren = r_en;
                if (r_en) begin
                    n_reads++;
                    ren_run++;
                    if (ren_run > ren_max) ren_max = ren_run;
                end else ren_run = 0;
            end
            @(posedge r_clk);
            #1;
            if (s_ren && fq.size() > 0) begin
                cq.push_back(fq[0]);
                dataout = fq.pop_front();
            end else dataout = SZ'($urandom);
            #1;
            emptyN = (fq.size() > 0) && gate;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int base, r0;
        clrN = 1'b0; flush = 1'b0; word_ready = 1'b0;
        #2;
        chk("reset_r_en", r_en, 0);
        chk("reset_valid", word_valid, 0);
        chk("reset_word", word_out, 0);
        chk("reset_cnt", word_cnt, 0);
        cyc(2);
        clrN = 1'b1;

        // Reset mid-stream: one held word plus two entries in the assembler.
        for (int i = 1; i <= 6; i++) fq.push_back(8'hE0 + SZ'(i));
        cyc(14);
        chk("pre_rst_valid", word_valid, 1);
        chk("pre_rst_word", word_out, 32'hE4E3E2E1);
        clrN = 1'b0;
        #1;
        chk("rst_r_en", r_en, 0);
        chk("rst_valid", word_valid, 0);
        chk("rst_word", word_out, 0);
        cyc(2);
        clrN = 1'b1;
        cyc(1);

        // Streaming with downstream always ready.
        word_ready = 1'b1;
        ren_max = 0;
        base = n_words;
        for (int i = 1; i <= 8; i++) fq.push_back(SZ'(8'h11 * i));
        wait_words(base + 2, 40, "stream_words");
        if (n_words >= base + 2) begin
            chk("stream_w1", wlog[base], 32'h44332211);
            chk("stream_c1", cntlog[base], 4);
            chk("stream_w2", wlog[base+1], 32'h88776655);
            chk("stream_gap", cyclog[base+1] - cyclog[base], 4);
        end
        chk("stream_run", ren_max, 8);
        cyc(3);

        // Backpressure: one word held, assembler full, reads stop at 8.
        word_ready = 1'b0;
        base = n_words;
        r0 = n_reads;
        for (int i = 1; i <= 12; i++) fq.push_back(8'h30 + SZ'(i));
        cyc(30);
        chk("bp_reads", n_reads - r0, 8);
        chk("bp_valid", word_valid, 1);
        chk("bp_word", word_out, 32'h34333231);
        chk("bp_r_en", r_en, 0);
        word_ready = 1'b1;
        wait_words(base + 3, 60, "bp_words");
        if (n_words >= base + 3) begin
            chk("bp_w2", wlog[base+1], 32'h38373635);
            chk("bp_w3", wlog[base+2], 32'h3C3B3A39);
        end
        cyc(3);

        // Empty gaps: emptyN toggles, downstream randomly stalls.
        base = n_words;
        for (int i = 0; i < 16; i++) fq.push_back(SZ'($urandom));
        for (int i = 0; i < 80; i++) begin
            gate = ~gate;
            word_ready = ($urandom % 3) != 0;
            cyc(1);
        end
        gate = 1'b1;
        word_ready = 1'b1;
        wait_words(base + 4, 40, "gap_words");
        cyc(3);
        chk("gap_drained", cq.size(), 0);

        // Flush of a three-entry partial word.
        fq.push_back(8'hA1); fq.push_back(8'hB2); fq.push_back(8'hC3);
        cyc(8);
        base = n_words;
        flush = 1'b1;
        cyc(5);
        flush = 1'b0;
        cyc(2);
        chk("flush_nwords", n_words - base, 1);
        if (n_words > base) begin
            chk("flush_word", wlog[base], 32'h00C3B2A1);
            chk("flush_cnt", cntlog[base], 3);
        end

        // Flush with nothing assembled produces no word.
        base = n_words;
        flush = 1'b1;
        cyc(5);
        flush = 1'b0;
        cyc(2);
        chk("flush_empty", n_words - base, 0);

        // Flush race: flush arrives while the third read is still in flight.
        fq.push_back(8'hD1); fq.push_back(8'hD2);
        cyc(6);
        base = n_words;
        fq.push_back(8'hD3);
        cyc(1);
        flush = 1'b1;
        cyc(5);
        flush = 1'b0;
        cyc(2);
        chk("race_nwords", n_words - base, 1);
        if (n_words > base) begin
            chk("race_word", wlog[base], 32'h00D3D2D1);
            chk("race_cnt", cntlog[base], 3);
        end

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            word_ready = ($urandom % 4) != 0;
            gate = ($urandom % 4) != 0;
            flush = ($urandom % 30) == 0;
            if (($urandom % 3) != 0) fq.push_back(SZ'($urandom));
            cyc(1);
        end
        flush = 1'b0; gate = 1'b1; word_ready = 1'b1;
        cyc(600);
        flush = 1'b1;
        cyc(6);
        flush = 1'b0;
        cyc(4);
        chk("final_fifo_empty", fq.size(), 0);
        chk("final_all_delivered", cq.size(), 0);
        chk("final_valid", word_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
